sw_scheduler: RTL

Job scheduler that shares one `SW_core` Smith-Waterman engine between `NREQ` requesters, such as the UART-fed Avalon wrapper and an on-chip test-pattern source. It arbitrates requests round-robin, latches the granted job and drives the core's input handshake. It then collects the core result and returns it to the owning requester over a per-requester response handshake. It sits between the requester wrappers and `SW_core`; the core's active-high `rst` is driven by `~rst_n` at the top level.

---
 rtl/sw_pkg.sv | 29 ++
 rtl/sw_rr_arbiter.sv | 35 +++
 rtl/sw_scheduler.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared constants, scheduler state encoding and helpers for the Smith-Waterman
// job scheduler and its arbiter.
package sw_pkg;

    localparam int REF_MAX_LENGTH  = 128;
    localparam int READ_MAX_LENGTH = 128;
    localparam int SEQ_W           = 256;
    localparam int LEN_W           = 8;
    localparam int SCORE_W         = 10;
    localparam int POS_W           = 7;

    localparam int signed MATCH_SCORE    = 1;
    localparam int signed MISMATCH_SCORE = -4;
    localparam int signed GAP_OPEN       = -6;
    localparam int signed GAP_EXTEND     = -1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sw_sched_state_t;

    // A length is usable by the core only when it is in 1..max_len.
    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/sw_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// as a one-hot vector plus its index.
module sw_rr_arbiter import sw_pkg::*; #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;
    int   sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk the requesters circularly starting at ptr.
            sum = int'(ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            if (!found && req[sum[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[sum[IDX_W-1:0]]   = 1'b1;
                grant_idx               = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sw_scheduler.sv
// Shares one SW_core between NREQ requesters: round-robin accept, issue to the
// core, collect the result and hand it back to the owning requester.
module sw_scheduler import sw_pkg::*; #(
    parameter int NREQ    = 2,
    parameter int SEQ_W   = 256,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][SEQ_W-1:0] req_ref,
    input  logic [NREQ-1:0][SEQ_W-1:0] req_read,
    input  logic [NREQ-1:0][LEN_W-1:0] req_ref_len,
    input  logic [NREQ-1:0][LEN_W-1:0] req_read_len,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [SCORE_W-1:0]         rsp_score,
    output logic [POS_W-1:0]           rsp_column,
    output logic [POS_W-1:0]           rsp_row,
    output logic                       rsp_err,
    input  logic                       core_o_ready,
    output logic                       core_i_valid,
    output logic [SEQ_W-1:0]           core_ref,
    output logic [SEQ_W-1:0]           core_read,
    output logic [LEN_W-1:0]           core_ref_len,
    output logic [LEN_W-1:0]           core_read_len,
    output logic                       core_i_ready,
    input  logic                       core_o_valid,
    input  logic [SCORE_W-1:0]         core_score,
    input  logic [POS_W-1:0]           core_column,
    input  logic [POS_W-1:0]           core_row,
    output logic                       busy,
    output logic [15:0]                jobs_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    sw_sched_state_t    state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, owner_q, grant_idx;
    logic [NREQ-1:0]    grant;
    logic [SEQ_W-1:0]   ref_q, read_q;
    logic [LEN_W-1:0]   ref_len_q, read_len_q;
    logic [SCORE_W-1:0] score_q;
    logic [POS_W-1:0]   column_q, row_q;
    logic               err_q;
    logic [15:0]        jobs_done_q;
    logic               accept, job_legal, core_in_hs, core_out_hs, rsp_take;

    sw_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept      = (state_q == S_IDLE) && (|grant);
    assign job_legal   = len_legal(32'(req_ref_len[grant_idx]), MAX_LEN)
                      && len_legal(32'(req_read_len[grant_idx]), MAX_LEN);
    assign core_in_hs  = (state_q == S_ISSUE) && core_o_ready;
    assign core_out_hs = (state_q == S_WAIT) && core_o_valid;
    assign rsp_take    = (state_q == S_RESP) && rsp_ready[owner_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)      state_d = job_legal ? S_ISSUE : S_RESP;
            S_ISSUE: if (core_in_hs)  state_d = S_WAIT;
            S_WAIT:  if (core_out_hs) state_d = S_RESP;
            S_RESP:  if (rsp_take)    state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state_q == S_IDLE) ? grant : '0;
        core_i_valid = (state_q == S_ISSUE);
        core_i_ready = (state_q == S_WAIT);
        busy         = (state_q != S_IDLE);
        rsp_valid    = '0;
        if (state_q == S_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            ref_q       <= '0;
            read_q      <= '0;
            ref_len_q   <= '0;
            read_len_q  <= '0;
            score_q     <= '0;
            column_q    <= '0;
            row_q       <= '0;
            err_q       <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            if (accept) begin
                owner_q    <= grant_idx;
                rr_ptr_q   <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                ref_q      <= req_ref[grant_idx];
                read_q     <= req_read[grant_idx];
                ref_len_q  <= req_ref_len[grant_idx];
                read_len_q <= req_read_len[grant_idx];
                // Rejected jobs answer straight away with zeroed result fields.
                if (!job_legal) begin
                    err_q    <= 1'b1;
                    score_q  <= '0;
                    column_q <= '0;
                    row_q    <= '0;
                end
            end
            if (core_out_hs) begin
                score_q  <= core_score;
                column_q <= core_column;
                row_q    <= core_row;
                err_q    <= 1'b0;
            end
            if (rsp_take) begin
                jobs_done_q <= jobs_done_q + 16'd1;
            end
        end
    end

    assign core_ref      = ref_q;
    assign core_read     = read_q;
    assign core_ref_len  = ref_len_q;
    assign core_read_len = read_len_q;
    assign rsp_score     = score_q;
    assign rsp_column    = column_q;
    assign rsp_row       = row_q;
    assign rsp_err       = err_q;
    assign jobs_done     = jobs_done_q;

endmodule
